// File: rtl/elevator_scan_ctrl.sv
// Multi-request elevator car controller: pending-request bitmap served in SCAN
// order, with per-floor travel time, timed door, emergency halt and range check.
module elevator_scan_ctrl #(
   parameter int NUM_FLOORS    = 16,
   parameter int FLOOR_W       = 4,
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  emergency,
   input  logic                  req_valid,
   input  logic [FLOOR_W-1:0]    req_floor,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic [1:0]            direction,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  arrived,
   output logic                  req_err
);

   localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TCW-1:0] TC_LAST = TCW'(TRAVEL_CYCLES - 1);
   localparam logic [DCW-1:0] DC_LAST = DCW'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR, S_EMERG} state_t;

   state_t                r_state;
   logic [FLOOR_W-1:0]    r_floor;
   logic [TCW-1:0]        r_tcnt;
   logic [DCW-1:0]        r_dcnt;
   logic                  r_pref;
   logic [NUM_FLOORS-1:0] r_pending;
   logic [1:0]            r_dir;
   logic                  r_door;
   logic                  r_arrived;
   logic                  r_req_err;

   state_t                w_state_nx;
   logic [FLOOR_W-1:0]    w_floor_nx;
   logic [FLOOR_W-1:0]    w_step;
   logic [TCW-1:0]        w_tcnt_nx;
   logic [DCW-1:0]        w_dcnt_nx;
   logic                  w_pref_nx;
   logic [NUM_FLOORS-1:0] w_set;
   logic [NUM_FLOORS-1:0] w_clr;
   logic                  w_arr_nx;
   logic                  w_err_nx;
   logic                  w_accept;
   logic                  w_in_range;
   logic                  w_door_hold;
   logic [1:0]            w_dir_nx;

   function automatic logic [NUM_FLOORS-1:0] f_onehot(
      input logic [FLOOR_W-1:0] f
   );
      logic [NUM_FLOORS-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (f == FLOOR_W'(i)) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic f_hit(
      input logic [NUM_FLOORS-1:0] p,
      input logic [FLOOR_W-1:0]    f
   );
      return |(p & f_onehot(f));
   endfunction

   // Any request strictly beyond floor f in the given direction.
   function automatic logic f_ahead(
      input logic [NUM_FLOORS-1:0] p,
      input logic [FLOOR_W-1:0]    f,
      input logic                  up
   );
      logic a;
      a = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (up ? (FLOOR_W'(i) > f) : (FLOOR_W'(i) < f)) a = a | p[i];
      return a;
   endfunction

   assign w_accept    = req_valid && !emergency && (r_state != S_EMERG);
   assign w_in_range  = 32'(req_floor) < 32'(NUM_FLOORS);
   assign w_door_hold = w_accept && w_in_range && (r_state == S_DOOR)
                        && (req_floor == r_floor);
   assign w_set       = (w_accept && w_in_range && !w_door_hold)
                        ? f_onehot(req_floor) : '0;
   assign w_err_nx    = w_accept && !w_in_range;
   assign w_step      = r_pref ? r_floor + FLOOR_W'(1)
                               : r_floor - FLOOR_W'(1);

   always_comb begin
      w_state_nx = r_state;
      w_floor_nx = r_floor;
      w_tcnt_nx  = r_tcnt;
      w_dcnt_nx  = r_dcnt;
      w_pref_nx  = r_pref;
      w_clr      = '0;
      w_arr_nx   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (|r_pending) begin
               if (f_hit(r_pending, r_floor)) begin
                  w_clr      = f_onehot(r_floor);
                  w_state_nx = S_DOOR;
                  w_dcnt_nx  = '0;
               end else begin
                  if (!f_ahead(r_pending, r_floor, r_pref))
                     w_pref_nx = !r_pref;
                  w_state_nx = S_MOVE;
                  w_tcnt_nx  = '0;
               end
            end
         end
         S_MOVE: begin
            if (r_tcnt == TC_LAST) begin
               w_tcnt_nx  = '0;
               w_floor_nx = w_step;
               if (f_hit(r_pending, w_step)) begin
                  w_clr      = f_onehot(w_step);
                  w_arr_nx   = 1'b1;
                  w_state_nx = S_DOOR;
                  w_dcnt_nx  = '0;
               end else if (!f_ahead(r_pending, w_step, r_pref)) begin
                  w_state_nx = S_IDLE;
               end
            end else begin
               w_tcnt_nx = r_tcnt + TCW'(1);
            end
         end
         S_DOOR: begin
            if (w_door_hold) begin
               w_dcnt_nx = '0;
            end else if (r_dcnt == DC_LAST) begin
               w_state_nx = S_IDLE;
               w_dcnt_nx  = '0;
            end else begin
               w_dcnt_nx = r_dcnt + DCW'(1);
            end
         end
         S_EMERG: begin
            if (!emergency) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
      // Emergency overrides everything except reset; partial travel is lost.
      if (emergency) begin
         w_state_nx = S_EMERG;
         w_floor_nx = r_floor;
         w_tcnt_nx  = '0;
         w_dcnt_nx  = '0;
         w_pref_nx  = r_pref;
         w_clr      = '1;
         w_arr_nx   = 1'b0;
      end
   end

   always_comb begin
      w_dir_nx = 2'b00;
      if (w_state_nx == S_MOVE)
         w_dir_nx = w_pref_nx ? 2'b01 : 2'b10;
      else if (w_state_nx == S_EMERG)
         w_dir_nx = 2'b11;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_floor   <= '0;
         r_tcnt    <= '0;
         r_dcnt    <= '0;
         r_pref    <= 1'b1;
         r_pending <= '0;
         r_dir     <= 2'b00;
         r_door    <= 1'b0;
         r_arrived <= 1'b0;
         r_req_err <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_floor   <= w_floor_nx;
         r_tcnt    <= w_tcnt_nx;
         r_dcnt    <= w_dcnt_nx;
         r_pref    <= w_pref_nx;
         r_pending <= (r_pending | w_set) & ~w_clr;
         r_dir     <= w_dir_nx;
         r_door    <= (w_state_nx == S_DOOR);
         r_arrived <= w_arr_nx;
         r_req_err <= w_err_nx;
      end
   end

   assign current_floor = r_floor;
   assign direction     = r_dir;
   assign door_open     = r_door;
   assign pending       = r_pending;
   assign arrived       = r_arrived;
   assign req_err       = r_req_err;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl: default 16-floor build plus a
// 10-floor build sharing the same stimulus for out-of-range requests.
module tb_elevator_scan_ctrl;

   logic        clk;
   logic        reset;
   logic        emergency;
   logic        req_valid;
   logic [3:0]  req_floor;

   logic [3:0]  cf;
   logic [1:0]  dir;
   logic        door;
   logic [15:0] pend;
   logic        arr;
   logic        err;

   logic [3:0]  cf10;
   logic [1:0]  dir10;
   logic        door10;
   logic [9:0]  pend10;
   logic        arr10;
   logic        err10;

   int n_chk  = 0;
   int n_fail = 0;

   logic       mon_en = 1'b0;
   logic [1:0] last_dir;
   int         rev_cnt;

   typedef struct {
      logic        rst;
      logic        em;
      logic        rv;
      logic [3:0]  rf;
      logic [3:0]  e_floor;
      logic [1:0]  e_dir;
      logic        e_door;
      logic [15:0] e_pend;
      logic        e_arr;
      logic        e_err10;
      logic [9:0]  e_pend10;
   } vec_t;

   vec_t tv[17];

   elevator_scan_ctrl u_dut (
      .clk           (clk),
      .reset         (reset),
      .emergency     (emergency),
      .req_valid     (req_valid),
      .req_floor     (req_floor),
      .current_floor (cf),
      .direction     (dir),
      .door_open     (door),
      .pending       (pend),
      .arrived       (arr),
      .req_err       (err)
   );

   elevator_scan_ctrl #(.NUM_FLOORS(10)) u_d10 (
      .clk           (clk),
      .reset         (reset),
      .emergency     (emergency),
      .req_valid     (req_valid),
      .req_floor     (req_floor),
      .current_floor (cf10),
      .direction     (dir10),
      .door_open     (door10),
      .pending       (pend10),
      .arrived       (arr10),
      .req_err       (err10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts direction reversals, ignoring stops in between.
   always @(negedge clk) begin
      if (!mon_en) begin
         rev_cnt  <= 0;
         last_dir <= 2'b00;
      end else if (dir == 2'b01 || dir == 2'b10) begin
         if (last_dir != 2'b00 && dir != last_dir)
            rev_cnt <= rev_cnt + 1;
         last_dir <= dir;
      end
   end

   function automatic vec_t mk(
      input logic rst, em, rv,
      input logic [3:0] rf, ef,
      input logic [1:0] ed,
      input logic edo,
      input logic [15:0] ep,
      input logic ea, ee,
      input logic [9:0] ep10
   );
      vec_t v;
      v.rst = rst; v.em = em; v.rv = rv; v.rf = rf;
      v.e_floor = ef; v.e_dir = ed; v.e_door = edo;
      v.e_pend = ep; v.e_arr = ea; v.e_err10 = ee;
      v.e_pend10 = ep10;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      n_chk++;
      if (32'(cf10) >= 32'd10) begin
         n_fail++;
         $display("FAIL range10: floor %0d expected < 10", cf10);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; emergency = 1'b0; req_valid = 1'b0; req_floor = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic req(input logic [3:0] f);
      req_valid = 1'b1;
      req_floor = f;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_arrive(input string nm, input logic [3:0] exp,
                              input int budget);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (arr) begin
            got = 1'b1;
            break;
         end
      end
      n_chk++;
      if (!got || cf !== exp) begin
         n_fail++;
         $display("FAIL %s: arrived=%0d floor %0d expected %0d",
                  nm, got, cf, exp);
      end
   endtask

   task automatic wait_idle(input string nm, input int budget);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!door && dir == 2'b00) begin
            got = 1'b1;
            break;
         end
      end
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s: door %0d dir %0d expected idle", nm, door, dir);
      end
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         reset     = tv[i].rst;
         emergency = tv[i].em;
         req_valid = tv[i].rv;
         req_floor = tv[i].rf;
         tick();
         chk($sformatf("row%0d floor", i), 32'(cf), 32'(tv[i].e_floor));
         chk($sformatf("row%0d dir", i), 32'(dir), 32'(tv[i].e_dir));
         chk($sformatf("row%0d door", i), 32'(door), 32'(tv[i].e_door));
         chk($sformatf("row%0d pend", i), 32'(pend), 32'(tv[i].e_pend));
         chk($sformatf("row%0d arr", i), 32'(arr), 32'(tv[i].e_arr));
         chk($sformatf("row%0d err10", i), 32'(err10),
             32'(tv[i].e_err10));
         chk($sformatf("row%0d pend10", i), 32'(pend10),
             32'(tv[i].e_pend10));
      end
      reset = 1'b0; emergency = 1'b0; req_valid = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Range check and reset rows, from a freshly reset car.
      tv[0]  = mk(0, 0, 1, 10, 0, 2'b00, 0, 16'h0400, 0, 1, 10'h000);
      tv[1]  = mk(1, 0, 1,  3, 0, 2'b00, 0, 16'h0000, 0, 0, 10'h000);
      tv[2]  = mk(0, 0, 1,  9, 0, 2'b00, 0, 16'h0200, 0, 0, 10'h200);
      tv[3]  = mk(0, 0, 1, 15, 0, 2'b01, 0, 16'h8200, 0, 1, 10'h200);
      tv[4]  = mk(1, 0, 0,  0, 0, 2'b00, 0, 16'h0000, 0, 0, 10'h000);
      tv[5]  = mk(0, 0, 1, 12, 0, 2'b00, 0, 16'h1000, 0, 1, 10'h000);
      tv[6]  = mk(0, 0, 0,  0, 0, 2'b01, 0, 16'h1000, 0, 0, 10'h000);
      tv[7]  = mk(1, 0, 0,  0, 0, 2'b00, 0, 16'h0000, 0, 0, 10'h000);
      // Door at current floor and restart, from idle at floor 4.
      tv[8]  = mk(0, 0, 1,  4, 4, 2'b00, 0, 16'h0010, 0, 0, 10'h010);
      tv[9]  = mk(0, 0, 0,  0, 4, 2'b00, 1, 16'h0000, 0, 0, 10'h000);
      tv[10] = mk(0, 0, 0,  0, 4, 2'b00, 1, 16'h0000, 0, 0, 10'h000);
      tv[11] = mk(0, 0, 1,  4, 4, 2'b00, 1, 16'h0000, 0, 0, 10'h000);
      tv[12] = mk(0, 0, 0,  0, 4, 2'b00, 1, 16'h0000, 0, 0, 10'h000);
      tv[13] = mk(0, 0, 0,  0, 4, 2'b00, 1, 16'h0000, 0, 0, 10'h000);
      tv[14] = mk(0, 0, 0,  0, 4, 2'b00, 0, 16'h0000, 0, 0, 10'h000);
      tv[15] = mk(0, 1, 1,  6, 4, 2'b11, 0, 16'h0000, 0, 0, 10'h000);
      tv[16] = mk(0, 0, 0,  0, 4, 2'b00, 0, 16'h0000, 0, 0, 10'h000);

      do_reset();
      chk("rst floor", 32'(cf), 32'd0);
      chk("rst dir", 32'(dir), 32'd0);
      chk("rst door", 32'(door), 32'd0);
      chk("rst pend", 32'(pend), 32'd0);
      chk("rst arr", 32'(arr), 32'd0);
      chk("rst err", 32'(err), 32'd0);

      run_rows(0, 7);

      // Floor 15 is legal in the default build.
      req_valid = 1'b1; req_floor = 4'd15;
      tick();
      req_valid = 1'b0;
      chk("t4 pend15", 32'(pend), 32'h8000);
      chk("t4 err16", 32'(err), 32'd0);
      chk("t4 err10", 32'(err10), 32'd1);
      tick();
      chk("t4 err10 pulse", 32'(err10), 32'd0);
      wait_arrive("t4 reach15", 4'd15, 100);

      // Single request to floor 5.
      do_reset();
      req(4'd5);
      chk("t1 pend", 32'(pend), 32'h0020);
      chk("t1 dir idle", 32'(dir), 32'd0);
      tick();
      chk("t1 dir up", 32'(dir), 32'd1);
      repeat (19) tick();
      chk("t1 floor4", 32'(cf), 32'd4);
      chk("t1 no arr", 32'(arr), 32'd0);
      tick();
      chk("t1 floor5", 32'(cf), 32'd5);
      chk("t1 arr", 32'(arr), 32'd1);
      chk("t1 door1", 32'(door), 32'd1);
      chk("t1 dir stop", 32'(dir), 32'd0);
      chk("t1 pend0", 32'(pend), 32'd0);
      tick();
      chk("t1 arr pulse", 32'(arr), 32'd0);
      chk("t1 door2", 32'(door), 32'd1);
      tick();
      chk("t1 door3", 32'(door), 32'd1);
      tick();
      chk("t1 door closed", 32'(door), 32'd0);
      chk("t1 dir end", 32'(dir), 32'd0);

      // SCAN order 5, 7, then 1.
      do_reset();
      req(4'd3);
      wait_arrive("t2 setup3", 4'd3, 50);
      wait_idle("t2 idle3", 10);
      mon_en = 1'b1;
      req(4'd5);
      req(4'd1);
      req(4'd7);
      wait_arrive("t2 stop5", 4'd5, 40);
      wait_arrive("t2 stop7", 4'd7, 40);
      wait_arrive("t2 stop1", 4'd1, 60);
      wait_idle("t2 idle1", 10);
      chk("t2 reversals", 32'(rev_cnt), 32'd1);
      chk("t2 pend0", 32'(pend), 32'd0);
      mon_en = 1'b0;

      // Emergency while travelling toward 6 and 9.
      do_reset();
      req(4'd6);
      req(4'd9);
      repeat (6) tick();
      chk("t3 pre floor", 32'(cf), 32'd1);
      chk("t3 pre pend", 32'(pend), 32'h0240);
      emergency = 1'b1;
      tick();
      chk("t3 em dir", 32'(dir), 32'd3);
      chk("t3 em pend", 32'(pend), 32'd0);
      chk("t3 em floor", 32'(cf), 32'd1);
      chk("t3 em door", 32'(door), 32'd0);
      req_valid = 1'b1; req_floor = 4'd3;
      tick();
      req_valid = 1'b0;
      chk("t3 em drop", 32'(pend), 32'd0);
      chk("t3 em noerr", 32'(err), 32'd0);
      emergency = 1'b0;
      tick();
      chk("t3 exit dir", 32'(dir), 32'd0);
      chk("t3 exit floor", 32'(cf), 32'd1);
      req(4'd2);
      tick();
      chk("t3 resume dir", 32'(dir), 32'd1);
      repeat (3) tick();
      chk("t3 resume floor1", 32'(cf), 32'd1);
      tick();
      chk("t3 floor2", 32'(cf), 32'd2);
      chk("t3 arr2", 32'(arr), 32'd1);

      do_reset();
      req(4'd4);
      wait_arrive("t5 setup4", 4'd4, 40);
      wait_idle("t5 idle4", 10);
      run_rows(8, 16);

      // Reset during travel with counter at 2.
      req(4'd8);
      tick();
      tick();
      tick();
      chk("t6 pre floor", 32'(cf), 32'd4);
      chk("t6 pre dir", 32'(dir), 32'd1);
      reset = 1'b1; req_valid = 1'b1; req_floor = 4'd7;
      tick();
      chk("t6 floor", 32'(cf), 32'd0);
      chk("t6 dir", 32'(dir), 32'd0);
      chk("t6 door", 32'(door), 32'd0);
      chk("t6 pend", 32'(pend), 32'd0);
      chk("t6 arr", 32'(arr), 32'd0);
      chk("t6 err", 32'(err), 32'd0);
      reset = 1'b0; req_valid = 1'b0;
      tick();
      chk("t6 post pend", 32'(pend), 32'd0);
      chk("t6 post dir", 32'(dir), 32'd0);
      req(4'd1);
      tick();
      repeat (3) tick();
      chk("t6 still0", 32'(cf), 32'd0);
      tick();
      chk("t6 floor1", 32'(cf), 32'd1);
      chk("t6 arr1", 32'(arr), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
